seg7_multi_display: RTL



---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_multi_display_if.sv | 28 ++
 rtl/seg7_digit_decode.sv | 16 +
 rtl/seg7_multi_display.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and helpers for the multi-digit 7-segment display.
// Segment bytes are active-low with bit 7 as the decimal point.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [7:0] SEG_DASH = 8'hBF;

    // Entry n holds the segment byte for decimal digit n (entry 0 is the LSB slice).
    localparam logic [9:0][7:0] SEG_TABLE = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Largest value representable on n decimal digits (10^n - 1).
    function automatic int unsigned pow10_minus1(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned k = 0; k < n; k++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/seg7_multi_display_if.sv
// Input handshake bundle: value, blanking and decimal-point controls qualified by valid/ready.
// A transfer happens on a rising clock edge where in_valid and in_ready are both high.
interface seg7_multi_display_if #(
    parameter int WIDTH      = 14,
    parameter int NUM_DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_value;
    logic                  blank_lz;
    logic [NUM_DIGITS-1:0] dp_mask;

    modport master (
        output in_valid,
        output in_value,
        output blank_lz,
        output dp_mask,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_value,
        input  blank_lz,
        input  dp_mask,
        output in_ready
    );
endinterface

// File: rtl/seg7_digit_decode.sv
// Combinational BCD nibble to active-low segment byte; non-decimal nibbles go dark.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (nibble <= 4'd9) begin
            seg = SEG_TABLE[nibble];
        end
    end

endmodule

// File: rtl/seg7_multi_display.sv
// Binary-to-BCD display driver: accepts a value, runs a sequential double-dabble,
// then registers all segment bytes at once so the display never shows partial results.
module seg7_multi_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int WIDTH      = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    seg7_multi_display_if.slave     in_if,
    output logic [8*NUM_DIGITS-1:0] hex,
    output logic                    busy,
    output logic                    overflow,
    output state_t                  state_dbg
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("seg7_multi_display: NUM_DIGITS must be in 1..8");
    end
    if (WIDTH < 1 || WIDTH > 27) begin : g_bad_width
        $error("seg7_multi_display: WIDTH must be in 1..27");
    end

    localparam int          BCD_W   = 4 * NUM_DIGITS;
    localparam int          CNT_W   = 5;
    localparam logic [31:0] MAX_VAL = 32'(pow10_minus1(NUM_DIGITS));

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        value_q, value_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic [BCD_W-1:0]        bcd_adj;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic                    ovf_pend_q, ovf_pend_d;
    logic [8*NUM_DIGITS-1:0] hex_q, hex_d;
    logic                    overflow_q, overflow_d;
    logic [8*NUM_DIGITS-1:0] disp;
    logic [7:0]              seg_raw [NUM_DIGITS];
    logic                    in_ready_int;
    logic                    busy_int;

    // State register plus all datapath flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            value_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            blank_q    <= 1'b0;
            dp_q       <= '0;
            ovf_pend_q <= 1'b0;
            hex_q      <= '1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            blank_q    <= blank_d;
            dp_q       <= dp_d;
            ovf_pend_q <= ovf_pend_d;
            hex_q      <= hex_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_if.in_valid) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(1)) state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_int = (state_q == IDLE);
        busy_int     = (state_q != IDLE);
    end

    // Double-dabble correction: any nibble of 5 or more would exceed 9 after the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        value_d    = value_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        blank_d    = blank_q;
        dp_d       = dp_q;
        ovf_pend_d = ovf_pend_q;
        hex_d      = hex_q;
        overflow_d = overflow_q;
        unique case (state_q)
            IDLE: begin
                if (in_if.in_valid) begin
                    value_d    = in_if.in_value;
                    bcd_d      = '0;
                    cnt_d      = CNT_W'(WIDTH);
                    blank_d    = in_if.blank_lz;
                    dp_d       = in_if.dp_mask;
                    ovf_pend_d = (32'(in_if.in_value) > MAX_VAL);
                end
            end
            SHIFT: begin
                bcd_d   = {bcd_adj[BCD_W-2:0], value_q[WIDTH-1]};
                value_d = value_q << 1;
                cnt_d   = cnt_q - CNT_W'(1);
            end
            UPDATE: begin
                hex_d      = disp;
                overflow_d = ovf_pend_q;
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_digit_decode u_dec (
            .nibble (bcd_q[4*g +: 4]),
            .seg    (seg_raw[g])
        );
    end

    // Walk from the top digit down; zero_above stays set while every digit so far is zero
    always_comb begin
        logic       zero_above;
        logic [7:0] seg;
        zero_above = 1'b1;
        seg        = SEG_OFF;
        disp       = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (bcd_q[4*i +: 4] == 4'd0);
            if (ovf_pend_q) begin
                seg = SEG_DASH;
            end else begin
                seg = (blank_q && zero_above && i != 0) ? SEG_OFF : seg_raw[i];
                if (dp_q[i]) begin
                    seg[7] = 1'b0;
                end
            end
            disp[8*i +: 8] = seg;
        end
    end

    assign in_if.in_ready = in_ready_int;
    assign busy           = busy_int;
    assign hex            = hex_q;
    assign overflow       = overflow_q;
    assign state_dbg      = state_q;

endmodule
